// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit hex 7-segment driver with a per-frame
// input snapshot, leading-zero suppression, blanking and anti-ghosting dead time.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYC       = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W         = $clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || CLK_DIV < 2 ||
        DEAD_CYC < 0 || DEAD_CYC >= CLK_DIV) begin : g_param_check
        $fatal(1, "seg7_scan_driver: illegal NUM_DIGITS/CLK_DIV/DEAD_CYC combination");
    end

    // Bit k of the returned glyph lights segment 'a'+k.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_frame_tick;
    logic [4*NUM_DIGITS-1:0]   r_sh_value;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic [NUM_DIGITS-1:0]     r_sh_blank;
    logic                      r_sh_lz;
    logic [NUM_DIGITS-1:0]     r_an;
    logic [6:0]                r_seg;
    logic                      r_dp;

    logic                      w_slot_end;
    logic                      w_frame_end;
    logic                      w_load;
    logic [4*NUM_DIGITS-1:0]   w_cur_value;
    logic [NUM_DIGITS-1:0]     w_cur_dp;
    logic [NUM_DIGITS-1:0]     w_cur_blank;
    logic                      w_cur_lz;
    logic                      w_zero_run;
    logic [NUM_DIGITS-1:0]     w_visible;
    logic [3:0]                w_nibble;
    logic                      w_sel_dp;
    logic                      w_sel_vis;
    logic [NUM_DIGITS-1:0]     w_an_hot;
    logic                      w_lit;

    assign w_slot_end  = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_load      = en && (r_cnt == '0) && (r_idx == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
        end else if (en) begin
            r_frame_tick <= w_frame_end;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_frame_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_sh_lz    <= 1'b0;
        end else if (w_load) begin
            r_sh_value <= value;
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank;
            r_sh_lz    <= lz_en;
        end
    end

    // On the load edge decode from the incoming snapshot so slot 0 never mixes frames.
    assign w_cur_value = w_load ? value : r_sh_value;
    assign w_cur_dp    = w_load ? dp_in : r_sh_dp;
    assign w_cur_blank = w_load ? blank : r_sh_blank;
    assign w_cur_lz    = w_load ? lz_en : r_sh_lz;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_zero_run = 1'b1;
        w_visible  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run   = w_zero_run && (w_cur_value[4*i +: 4] == 4'h0);
            w_visible[i] = !w_cur_blank[i] && !(w_cur_lz && w_zero_run && (i != 0));
        end
    end

    always_comb begin
        w_nibble  = 4'h0;
        w_sel_dp  = 1'b0;
        w_sel_vis = 1'b0;
        w_an_hot  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble    = w_cur_value[4*i +: 4];
                w_sel_dp    = w_cur_dp[i];
                w_sel_vis   = w_visible[i];
                w_an_hot[i] = 1'b1;
            end
        end
    end

    assign w_lit = en && (r_cnt >= CNT_W'(DEAD_CYC)) && w_sel_vis;

    // Pin polarity is applied only here; everything upstream is active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= SEG_ACTIVE_LOW;
        end else begin
            r_an  <= (w_lit ? w_an_hot : '0) ^ AN_OFF;
            r_seg <= (w_lit ? hex_glyph(w_nibble) : 7'h00) ^ SEG_OFF;
            r_dp  <= (w_lit && w_sel_dp) ^ SEG_ACTIVE_LOW;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign digit_idx  = r_idx;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (active-high and active-low segments)
// compared cycle by cycle against a frame-position reference model.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int DEAD  = 1;
    localparam int FRAME = N * DIV;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_en;

    logic [6:0]  seg,   seg_b;
    logic        dp,    dp_b;
    logic [3:0]  an,    an_b;
    logic [1:0]  digit_idx, idx_b;
    logic        frame_tick, tick_b;

    int n_checks;
    int n_pass;

    // Reference model: position within the frame plus the captured snapshot.
    int          m_pos;
    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic        m_lz;
    logic [3:0]  e_an_hot;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_tick;
    logic [1:0]  e_idx;

    seg7_scan_driver #(
        .NUM_DIGITS(N), .CLK_DIV(DIV), .DEAD_CYC(DEAD),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in),
        .blank(blank), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(N), .CLK_DIV(DIV), .DEAD_CYC(DEAD),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in),
        .blank(blank), .lz_en(lz_en), .seg(seg_b), .dp(dp_b), .an(an_b),
        .digit_idx(idx_b), .frame_tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string seg_letters(input int n);
        case (n)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
            4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
            8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";  default: return "aefg";
        endcase
    endfunction

    function automatic logic [6:0] ref_glyph(input int n);
        string      s;
        logic [6:0] g;
        g = '0;
        s = seg_letters(n);
        for (int j = 0; j < s.len(); j++) g[int'(s[j]) - 97] = 1'b1;
        return g;
    endfunction

    function automatic bit ref_visible(input int d);
        bit upper_zero;
        upper_zero = ((m_value >> (4 * d)) == 16'h0);
        return !m_blank[d] && !(m_lz && d > 0 && upper_zero);
    endfunction

    function automatic logic [29:0] obs_vec();
        return {an, seg, dp, digit_idx, frame_tick, an_b, seg_b, dp_b, idx_b, tick_b};
    endfunction

    function automatic logic [29:0] exp_vec();
        return {~e_an_hot, e_seg, e_dp, e_idx, e_tick, ~e_an_hot, ~e_seg, ~e_dp, e_idx, e_tick};
    endfunction

    function automatic string obs_str();
        return $sformatf("an=%b seg=%b dp=%b idx=%0d tick=%b | an_b=%b seg_b=%b dp_b=%b idx_b=%0d tick_b=%b",
                         an, seg, dp, digit_idx, frame_tick, an_b, seg_b, dp_b, idx_b, tick_b);
    endfunction

    function automatic string exp_str();
        return $sformatf("an=%b seg=%b dp=%b idx=%0d tick=%b | an_b=%b seg_b=%b dp_b=%b idx_b=%0d tick_b=%b",
                         ~e_an_hot, e_seg, e_dp, e_idx, e_tick, ~e_an_hot, ~e_seg, ~e_dp, e_idx, e_tick);
    endfunction

    task automatic model_reset();
        m_pos    = 0;
        m_value  = '0;
        m_dp     = '0;
        m_blank  = '0;
        m_lz     = 1'b0;
        e_an_hot = '0;
        e_seg    = '0;
        e_dp     = 1'b0;
        e_tick   = 1'b0;
        e_idx    = '0;
    endtask

    // One clock: predict what the edge produces, then advance to the sampling edge.
    task automatic cycle();
        int d;
        int sub;
        e_an_hot = '0;
        e_seg    = '0;
        e_dp     = 1'b0;
        e_tick   = 1'b0;
        if (en) begin
            if (m_pos == 0) begin
                m_value = value;
                m_dp    = dp_in;
                m_blank = blank;
                m_lz    = lz_en;
            end
            d      = m_pos / DIV;
            sub    = m_pos % DIV;
            e_tick = (m_pos == FRAME - 1);
            if (sub >= DEAD && ref_visible(d)) begin
                e_an_hot = 4'(1 << d);
                e_seg    = ref_glyph(int'((m_value >> (4 * d)) & 16'hF));
                e_dp     = m_dp[d];
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        e_idx = 2'(m_pos / DIV);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run until the first slot of a fresh frame (snapshot just taken) is displayed.
    task automatic next_frame();
        do cycle(); while (m_pos != 1);
    endtask

    // Run until the outputs show digit d at slot cycle sub.
    task automatic show(input int d, input int sub);
        int target;
        target = (d * DIV + sub + 1) % FRAME;
        do cycle(); while (m_pos != target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an); else n_pass++;
        n_checks++; if (seg !== 7'b0000000) $display("FAIL reset_seg: got %b want 0000000", seg); else n_pass++;
        n_checks++; if (seg_b !== 7'b1111111) $display("FAIL reset_seg_lo: got %b want 1111111", seg_b); else n_pass++;
        n_checks++; if (dp !== 1'b0) $display("FAIL reset_dp: got %b want 0", dp); else n_pass++;
        n_checks++; if (digit_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", digit_idx); else n_pass++;
        n_checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", frame_tick); else n_pass++;

        value = 16'h1234;
        en    = 1'b1;
        rst_n = 1'b1;
        model_reset();
        repeat (6) cycle();
        n_checks++; if (an !== 4'b1101) $display("FAIL premid_an: got %b want 1101", an); else n_pass++;
        n_checks++; if (seg !== 7'h4F) $display("FAIL premid_seg: got %b want 1001111", seg); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (an !== 4'b1111) $display("FAIL async_rst_an: got %b want 1111", an); else n_pass++;
        n_checks++; if (seg !== 7'h00) $display("FAIL async_rst_seg: got %b want 0000000", seg); else n_pass++;
        n_checks++; if (digit_idx !== 2'd0) $display("FAIL async_rst_idx: got %0d want 0", digit_idx); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan_timing();
        int ticks;
        ticks = 0;
        value = 16'h1234;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            if (frame_tick === 1'b1) ticks++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL scan_c%0d: got %s want %s", i, obs_str(), exp_str());
            else n_pass++;
            if (i == 0) begin
                n_checks++; if (an !== 4'b1111) $display("FAIL scan_dead0: got an=%b want 1111", an); else n_pass++;
            end
            if (i == 1) begin
                n_checks++; if ({an, seg} !== {4'b1110, 7'b1100110}) $display("FAIL scan_digit0: got an=%b seg=%b want 1110/1100110", an, seg); else n_pass++;
            end
            if (i == 13) begin
                n_checks++; if ({an, seg} !== {4'b0111, 7'b0000110}) $display("FAIL scan_digit3: got an=%b seg=%b want 0111/0000110", an, seg); else n_pass++;
            end
        end
        n_checks++; if (ticks !== 2) $display("FAIL scan_tick_count: got %0d want 2", ticks); else n_pass++;
    endtask

    task automatic test_glyph_sweep();
        lz_en = 1'b0;
        for (int n = 0; n < 16; n++) begin
            value = {12'h000, 4'(n)};
            next_frame();
            show(0, 1);
            n_checks++;
            if ({an, seg, seg_b} !== {4'b1110, ref_glyph(n), ~ref_glyph(n)})
                $display("FAIL glyph_%0h: got an=%b seg=%b seg_b=%b want 1110/%b/%b", n, an, seg, seg_b, ref_glyph(n), ~ref_glyph(n));
            else n_pass++;
            if (n == 8) begin
                n_checks++; if (seg !== 7'b1111111) $display("FAIL glyph_8_const: got %b want 1111111", seg); else n_pass++;
            end
            if (n == 11) begin
                n_checks++; if (seg !== 7'b1111100) $display("FAIL glyph_b_const: got %b want 1111100", seg); else n_pass++;
            end
        end
    endtask

    task automatic test_snapshot();
        value = 16'h1234;
        next_frame();
        show(2, 1);
        value = 16'hABCD;
        show(2, 3);
        n_checks++; if (seg !== 7'h5B) $display("FAIL snap_old2: got %b want 1011011", seg); else n_pass++;
        show(3, 1);
        n_checks++; if ({an, seg} !== {4'b0111, 7'h06}) $display("FAIL snap_old1: got an=%b seg=%b want 0111/0000110", an, seg); else n_pass++;
        show(0, 1);
        n_checks++; if ({an, seg} !== {4'b1110, 7'h5E}) $display("FAIL snap_new_d: got an=%b seg=%b want 1110/1011110", an, seg); else n_pass++;
        show(1, 1);
        n_checks++; if (seg !== 7'h39) $display("FAIL snap_new_c: got %b want 0111001", seg); else n_pass++;
        show(3, 2);
        n_checks++; if (seg !== 7'h77) $display("FAIL snap_new_a: got %b want 1110111", seg); else n_pass++;
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL snap_model: got %s want %s", obs_str(), exp_str()); else n_pass++;
    endtask

    task automatic test_lz_blank_dp();
        int dp_cycles;
        lz_en = 1'b1;
        value = 16'h0040;
        next_frame();
        show(0, 1);
        n_checks++; if ({an, seg} !== {4'b1110, 7'h3F}) $display("FAIL lz40_d0: got an=%b seg=%b want 1110/0111111", an, seg); else n_pass++;
        show(1, 1);
        n_checks++; if ({an, seg} !== {4'b1101, 7'h66}) $display("FAIL lz40_d1: got an=%b seg=%b want 1101/1100110", an, seg); else n_pass++;
        show(2, 2);
        n_checks++; if (an !== 4'b1111) $display("FAIL lz40_d2: got an=%b want 1111", an); else n_pass++;
        show(3, 1);
        n_checks++; if (an !== 4'b1111) $display("FAIL lz40_d3: got an=%b want 1111", an); else n_pass++;

        value = 16'h0000;
        dp_in = 4'b1111;
        next_frame();
        show(0, 1);
        n_checks++; if ({an, seg, dp} !== {4'b1110, 7'h3F, 1'b1}) $display("FAIL lz0_d0: got an=%b seg=%b dp=%b want 1110/0111111/1", an, seg, dp); else n_pass++;
        for (int d = 1; d < N; d++) begin
            show(d, 2);
            n_checks++; if ({an, dp} !== {4'b1111, 1'b0}) $display("FAIL lz0_d%0d: got an=%b dp=%b want 1111/0", d, an, dp); else n_pass++;
        end

        lz_en     = 1'b0;
        value     = 16'h1234;
        blank     = 4'b0001;
        dp_in     = 4'b0100;
        dp_cycles = 0;
        next_frame();
        for (int i = 0; i < FRAME; i++) begin
            if (an === 4'b1110) begin
                n_checks++; $display("FAIL blank_d0: digit 0 lit (an=%b) want dark", an);
            end
            if (dp === 1'b1) begin
                dp_cycles++;
                n_checks++; if (an !== 4'b1011) $display("FAIL dp_slot: got an=%b with dp lit want 1011", an); else n_pass++;
            end
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL blank_dp_c%0d: got %s want %s", i, obs_str(), exp_str()); else n_pass++;
            cycle();
        end
        n_checks++; if (dp_cycles !== 3) $display("FAIL dp_count: got %0d want 3", dp_cycles); else n_pass++;
        blank = 4'b0000;
        dp_in = 4'b0000;
    endtask

    task automatic test_enable_gating();
        int ticks;
        value = 16'h1234;
        next_frame();
        show(1, 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_checks++;
            if ({an, digit_idx, frame_tick} !== {4'b1111, 2'd1, 1'b0})
                $display("FAIL en_off_c%0d: got an=%b idx=%0d tick=%b want 1111/1/0", i, an, digit_idx, frame_tick);
            else n_pass++;
        end
        en = 1'b1;
        cycle();
        n_checks++; if ({an, digit_idx} !== {4'b1101, 2'd2}) $display("FAIL en_resume: got an=%b idx=%0d want 1101/2", an, digit_idx); else n_pass++;
        ticks = (frame_tick === 1'b1) ? 1 : 0;
        for (int i = 1; i < FRAME; i++) begin
            cycle();
            if (frame_tick === 1'b1) ticks++;
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL en_model_c%0d: got %s want %s", i, obs_str(), exp_str()); else n_pass++;
        end
        n_checks++; if (ticks !== 1) $display("FAIL en_tick_count: got %0d want 1", ticks); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
            en = ($urandom_range(0, 9) != 0);
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_c%0d: got %s want %s", i, obs_str(), exp_str());
            else n_pass++;
        end
        en = 1'b1;
    endtask

    task automatic test_restart();
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({an, seg, dp, digit_idx, frame_tick, seg_b} !== {4'b1111, 7'h00, 1'b0, 2'd0, 1'b0, 7'h7F})
            $display("FAIL restart_async: got an=%b seg=%b dp=%b idx=%0d tick=%b seg_b=%b", an, seg, dp, digit_idx, frame_tick, seg_b);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if ({an, digit_idx} !== {4'b1111, 2'd0}) $display("FAIL restart_hold: got an=%b idx=%0d want 1111/0", an, digit_idx); else n_pass++;
        value = 16'h5678;
        blank = 4'h0;
        dp_in = 4'h0;
        lz_en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        show(0, 1);
        n_checks++; if ({an, seg, digit_idx} !== {4'b1110, 7'h7F, 2'd0}) $display("FAIL restart_load: got an=%b seg=%b idx=%0d want 1110/1111111/0", an, seg, digit_idx); else n_pass++;
        n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL restart_model: got %s want %s", obs_str(), exp_str()); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank    = '0;
        lz_en    = 1'b0;
        model_reset();
        test_reset();
        test_scan_timing();
        test_glyph_sweep();
        test_snapshot();
        test_lz_blank_dp();
        test_enable_gating();
        test_random();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
